rect_plotter: RTL
=================

Name: rect_plotter

Overview:
- Sits directly downstream of the game-logic stage and upstream of the DE2 VGA adapter.
- On each startPlot pulse it captures one object's old and new rectangles.
- It first erases the old rectangle with the background colour, then draws the new rectangle in the object's colour.
- Output is one pixel per clock as an (x, y, colour, plot) stream.

Parameters:
- MAX_X, 159, last visible column
- MAX_Y, 119, last visible row
- BG_COLOUR, 3'b000, erase colour
- BALL_COLOUR, 3'b111, colour for object 2'b00
- PADDLE_COLOUR, 3'b010, colour for object 2'b01
- BLOCK_COLOUR, 3'b100, colour for object 2'b10

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- startPlot  in  1  one-cycle request from game logic
- object  in  2  00 ball, 01 paddle, 10 block, 11 none
- newX  in  8  new rectangle left column
- newY  in  7  new rectangle top row
- oldX  in  8  old rectangle left column
- oldY  in  7  old rectangle top row
- sizeX  in  8  rectangle width in pixels
- sizeY  in  7  rectangle height in pixels
- vga_x  out  8  pixel column to adapter
- vga_y  out  7  pixel row to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write strobe to adapter
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when a request finishes
- missed  out  1  sticky flag: a request was dropped

Behaviour:
- Reset (resetn low, async): state IDLE; vga_x=0, vga_y=0, vga_colour=BG_COLOUR, vga_plot=0, busy=0, done=0, missed=0; all capture registers cleared.
- States: IDLE -> ERASE -> DRAW -> FIN -> IDLE.
- IDLE:
  - startPlot=1 with object!=11 captures all inputs and the object colour; next state ERASE.
  - startPlot with object=11 is ignored.
- ERASE:
  - Raster-scans the old rectangle row-major: x from oldX to oldX+sizeX-1, inner; y from oldY to oldY+sizeY-1, outer.
  - One pixel per cycle; vga_colour=BG_COLOUR.
  - The cycle after the last pixel, the scan starts on the new rectangle; state DRAW.
- DRAW: same scan over the new rectangle with the captured object colour; after the last pixel, state FIN.
- FIN: vga_plot=0, done=1 for exactly one cycle, busy=0 next cycle; state IDLE.
- Outputs are registered.
  - The first erase pixel appears on vga_* the cycle after startPlot is sampled.
  - Total latency startPlot->done = 1 + sizeX*sizeY (erase) + sizeX*sizeY (draw) + 1 cycles.
- busy is high from the cycle after capture through the FIN cycle inclusive.
- Arithmetic: pixel coordinates are formed as base + offset in 9-bit (x) and 8-bit (y) sums.
  - Any pixel with x>MAX_X or y>MAX_Y is clipped: the cycle is still consumed but vga_plot=0.
  - No wrap-around is ever emitted.
- Zero size: sizeX=0 or sizeY=0 skips both ERASE and DRAW and goes straight to FIN (done still pulses, 2-cycle latency).
- startPlot while busy: the request is dropped, missed is set and stays set until reset, and the current operation is unaffected.
- startPlot in the same cycle as FIN: dropped and sets missed. The request is accepted only in IDLE.
- Inputs may change freely after capture; only the captured copies are used.
- Reset mid-operation: the scan aborts immediately and vga_plot drops asynchronously; no done pulse is produced.

Optional Feature:
- Macro: SKIP_OVERLAP_EN.
- When defined, during ERASE any pixel that also lies inside the captured new rectangle has vga_plot=0; the cycle is still consumed and latency is unchanged. This reduces flicker on slow-moving objects.
- When undefined, every in-screen erase pixel is written.

Test Plan:
- Ball move, erase then draw:
  - Stimulus: object=00, old (51,4), new (52,5), size 4x4.
  - Required: 16 erase writes colour 000 starting at (51,4) in row-major order, then 16 draw writes colour 111 starting at (52,5); done exactly 34 cycles after startPlot.
- Paddle clipping:
  - Stimulus: object=01, newX=150, newY=2, size 16x1.
  - Required: draw phase asserts vga_plot only for x=150..159; 16 draw cycles still elapse.
- Zero size and object 11:
  - Stimulus: sizeX=0, object=00.
  - Required: no vga_plot; done 2 cycles after start. Also, startPlot with object=11 produces no busy and no done.
- Request dropped while busy:
  - Stimulus: second startPlot 5 cycles into a 4x4 job.
  - Required: first job completes unchanged; missed=1 and stays 1; no second job runs.
- Reset mid-draw:
  - Stimulus: resetn low during DRAW.
  - Required: vga_plot=0 and busy=0 immediately; no done pulse; next startPlot works normally.
- With SKIP_OVERLAP_EN:
  - Stimulus: ball 4x4 moving from (51,4) to (52,5).
  - Required: the 9 overlapping erase pixels have vga_plot=0 and 7 erase writes occur; latency is still 34 cycles.

Source files
------------

// File: rtl/rect_plotter_if.sv
// Request/pixel-stream bundle between game logic (master) and rect_plotter (slave).
interface rect_plotter_if;
    logic       startPlot;
    logic [1:0] object;
    logic [7:0] newX;
    logic [6:0] newY;
    logic [7:0] oldX;
    logic [6:0] oldY;
    logic [7:0] sizeX;
    logic [6:0] sizeY;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;
    logic       missed;

    modport master (
        output startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done, missed
    );

    modport slave (
        input  startPlot, object, newX, newY, oldX, oldY, sizeX, sizeY,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done, missed
    );
endinterface

// File: rtl/rect_plotter.sv
// Erases an object's old rectangle then draws its new one, one pixel per clock.
// Optional macro SKIP_OVERLAP_EN suppresses erase writes inside the new rectangle.
module rect_plotter #(
    parameter logic [7:0] MAX_X         = 8'd159,
    parameter logic [6:0] MAX_Y         = 7'd119,
    parameter logic [2:0] BG_COLOUR     = 3'b000,
    parameter logic [2:0] BALL_COLOUR   = 3'b111,
    parameter logic [2:0] PADDLE_COLOUR = 3'b010,
    parameter logic [2:0] BLOCK_COLOUR  = 3'b100
) (
    input  logic          clk,
    input  logic          resetn,
    rect_plotter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, FIN} state_t;

    state_t     state_q, state_d;
    logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d, size_x_q, size_x_d, off_x_q, off_x_d;
    logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d, size_y_q, size_y_d, off_y_q, off_y_d;
    logic [2:0] obj_colour_q, obj_colour_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;
    logic       busy_q, busy_d, done_q, done_d, missed_q, missed_d;

    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       on_screen, last_col, last_px, erase_keep;

    // Sums are one bit wider than the screen coordinates so off-screen pixels never alias.
    assign base_x    = (state_q == ERASE) ? old_x_q : new_x_q;
    assign base_y    = (state_q == ERASE) ? old_y_q : new_y_q;
    assign x_sum     = {1'b0, base_x} + {1'b0, off_x_q};
    assign y_sum     = {1'b0, base_y} + {1'b0, off_y_q};
    assign on_screen = (x_sum <= {1'b0, MAX_X}) && (y_sum <= {1'b0, MAX_Y});
    assign last_col  = (off_x_q == size_x_q - 8'd1);
    assign last_px   = last_col && (off_y_q == size_y_q - 7'd1);

`ifdef SKIP_OVERLAP_EN
    logic [8:0] new_x_end;
    logic [7:0] new_y_end;
    logic       in_new;
    assign new_x_end  = {1'b0, new_x_q} + {1'b0, size_x_q};
    assign new_y_end  = {1'b0, new_y_q} + {1'b0, size_y_q};
    assign in_new     = (x_sum >= {1'b0, new_x_q}) && (x_sum < new_x_end) &&
                        (y_sum >= {1'b0, new_y_q}) && (y_sum < new_y_end);
    assign erase_keep = !((state_q == ERASE) && in_new);
`else
    assign erase_keep = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        size_x_d     = size_x_q;
        size_y_d     = size_y_q;
        obj_colour_d = obj_colour_q;
        off_x_d      = off_x_q;
        off_y_d      = off_y_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        missed_d     = missed_q;

        case (state_q)
            IDLE: begin
                // busy_q is still high in the done cycle, so a request there is dropped too.
                if (bus.startPlot && busy_q) begin
                    missed_d = 1'b1;
                end else if (bus.startPlot && (bus.object != 2'b11)) begin
                    new_x_d  = bus.newX;
                    new_y_d  = bus.newY;
                    old_x_d  = bus.oldX;
                    old_y_d  = bus.oldY;
                    size_x_d = bus.sizeX;
                    size_y_d = bus.sizeY;
                    off_x_d  = 8'd0;
                    off_y_d  = 7'd0;
                    case (bus.object)
                        2'b00:   obj_colour_d = BALL_COLOUR;
                        2'b01:   obj_colour_d = PADDLE_COLOUR;
                        default: obj_colour_d = BLOCK_COLOUR;
                    endcase
                    state_d = ((bus.sizeX == 8'd0) || (bus.sizeY == 7'd0)) ? FIN : ERASE;
                end
            end
            ERASE, DRAW: begin
                busy_d       = 1'b1;
                vga_x_d      = x_sum[7:0];
                vga_y_d      = y_sum[6:0];
                vga_colour_d = (state_q == ERASE) ? BG_COLOUR : obj_colour_q;
                vga_plot_d   = on_screen && erase_keep;
                if (bus.startPlot) missed_d = 1'b1;
                if (last_px) begin
                    off_x_d = 8'd0;
                    off_y_d = 7'd0;
                    state_d = (state_q == ERASE) ? DRAW : FIN;
                end else if (last_col) begin
                    off_x_d = 8'd0;
                    off_y_d = off_y_q + 7'd1;
                end else begin
                    off_x_d = off_x_q + 8'd1;
                end
            end
            FIN: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
                if (bus.startPlot) missed_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            new_x_q      <= '0;
            new_y_q      <= '0;
            old_x_q      <= '0;
            old_y_q      <= '0;
            size_x_q     <= '0;
            size_y_q     <= '0;
            obj_colour_q <= '0;
            off_x_q      <= '0;
            off_y_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= BG_COLOUR;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            size_x_q     <= size_x_d;
            size_y_q     <= size_y_d;
            obj_colour_q <= obj_colour_d;
            off_x_q      <= off_x_d;
            off_y_q      <= off_y_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            missed_q     <= missed_d;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.missed     = missed_q;

endmodule
